// File: rtl/control_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : control_sequencer_pkg
//  Purpose  : Shared definitions for the control sequencer and its bench:
//             operation codes, state encodings, the control-word layout and
//             the state-to-control decode.
//  Contents : c_op_*   operation codes (LDA, MOVAB, ADD, CHAIN)
//             c_st_*   state encodings
//             state_t  FSM state type built on the c_st_* encodings
//             ctrl_t   packed control word (strobes, selects, busy, done)
//             decode_state / first_state helper functions
//  Revision : 1.0  initial release
// ============================================================================
package control_sequencer_pkg;

    // Operation codes, captured from op when start is accepted.
    localparam logic [1:0] c_op_lda   = 2'b00;
    localparam logic [1:0] c_op_movab = 2'b01;
    localparam logic [1:0] c_op_add   = 2'b10;
    localparam logic [1:0] c_op_chain = 2'b11;

    // State encodings. Codes 6 and 7 are unused and recover to IDLE.
    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_lda  = 3'd1;
    localparam logic [2:0] c_st_mov  = 3'd2;
    localparam logic [2:0] c_st_add  = 3'd3;
    localparam logic [2:0] c_st_wb   = 3'd4;
    localparam logic [2:0] c_st_done = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE = c_st_idle,
        ST_LDA  = c_st_lda,
        ST_MOV  = c_st_mov,
        ST_ADD  = c_st_add,
        ST_WB   = c_st_wb,
        ST_DONE = c_st_done
    } state_t;

    // Control word presented to the datapath.
    typedef struct packed {
        logic ra_in;
        logic rb_in;
        logic rz_in;
        logic ra_out;
        logic rb_out;
        logic rz_out;
        logic busy;
        logic done;
    } ctrl_t;

    // Moore decode: the control word is a pure function of the state.
    // Exactly one bus select at most is ever set by this table.
    function automatic ctrl_t decode_state(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            ST_LDA: begin
                c.ra_in = 1'b1;
                c.busy  = 1'b1;
            end
            ST_MOV: begin
                c.ra_out = 1'b1;
                c.rb_in  = 1'b1;
                c.busy   = 1'b1;
            end
            ST_ADD: begin
                c.rb_out = 1'b1;
                c.rz_in  = 1'b1;
                c.busy   = 1'b1;
            end
            ST_WB: begin
                c.rz_out = 1'b1;
                c.rb_in  = 1'b1;
                c.busy   = 1'b1;
            end
            ST_DONE: begin
                c.busy = 1'b1;
                c.done = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // First execute state for a freshly accepted operation.
    function automatic state_t first_state(input logic [1:0] opcode);
        state_t s;
        case (opcode)
            c_op_lda:   s = ST_LDA;
            c_op_movab: s = ST_MOV;
            c_op_add:   s = ST_ADD;
            default:    s = ST_LDA;   // CHAIN starts with the load
        endcase
        return s;
    endfunction

endpackage : control_sequencer_pkg
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : control_sequencer
//  Purpose  : Moore control FSM sequencing register strobes and bus selects
//             for a small A/B/Z datapath. One operation runs per accepted
//             start; done pulses for one cycle and op_count advances as the
//             FSM leaves DONE.
//  Ports    : clock      rising-edge clock
//             clear      asynchronous active-high reset
//             start      begin an operation (honoured only in IDLE)
//             op[1:0]    operation code, latched on acceptance
//             RAin/RBin/RZin     register load strobes
//             RAout/RBout/RZout  bus driver selects (mutually exclusive)
//             busy       high in every state except IDLE
//             done       one-cycle completion pulse
//             op_count   completed-operation count, wraps silently
//  Revision : 1.0  initial release
// ============================================================================
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [1:0]       op,
    output logic             RAin,
    output logic             RBin,
    output logic             RZin,
    output logic             RAout,
    output logic             RBout,
    output logic             RZout,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] op_count
);

    state_t            r_state;
    state_t            w_next;
    logic [1:0]        r_op;
    ctrl_t             r_ctrl;
    logic [CNT_W-1:0]  r_op_count;

    // Next-state selection. The latched opcode steers CHAIN through the
    // full LDA->MOV->ADD->WB path; single-step ops fall straight to DONE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = first_state(op);
                end
            end
            ST_LDA: begin
                w_next = (r_op == c_op_chain) ? ST_MOV : ST_DONE;
            end
            ST_MOV: begin
                w_next = (r_op == c_op_chain) ? ST_ADD : ST_DONE;
            end
            ST_ADD:  w_next = ST_WB;
            ST_WB:   w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // State, latched opcode, control word and counter. The control word is
    // registered from the decode of the next state, so it always equals the
    // decode of the current state while coming straight out of flops.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_state    <= ST_IDLE;
            r_op       <= c_op_lda;
            r_ctrl     <= '0;
            r_op_count <= '0;
        end else begin
            r_state <= w_next;
            r_ctrl  <= decode_state(w_next);
            if ((r_state == ST_IDLE) && start) begin
                r_op <= op;
            end
            // Count on the DONE-exit edge; an aborted operation never
            // reaches DONE and so never counts.
            if (r_state == ST_DONE) begin
                r_op_count <= r_op_count + CNT_W'(1);
            end
        end
    end

    assign RAin     = r_ctrl.ra_in;
    assign RBin     = r_ctrl.rb_in;
    assign RZin     = r_ctrl.rz_in;
    assign RAout    = r_ctrl.ra_out;
    assign RBout    = r_ctrl.rb_out;
    assign RZout    = r_ctrl.rz_out;
    assign busy     = r_ctrl.busy;
    assign done     = r_ctrl.done;
    assign op_count = r_op_count;

endmodule : control_sequencer
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_control_sequencer
//  Purpose  : Self-checking bench for control_sequencer. Attaches a small
//             A/B/Z datapath (bus mux + adder) to the default-width instance
//             and runs a second instance with CNT_W=2 on the same stimulus.
//  Revision : 1.0  initial release
// ============================================================================
module tb_control_sequencer;
    import control_sequencer_pkg::*;

    logic       clock = 1'b0;
    logic       clear = 1'b1;
    logic       start = 1'b0;
    logic [1:0] op    = 2'b00;

    logic       ra_in, rb_in, rz_in, ra_out, rb_out, rz_out, busy, done;
    logic [7:0] op_count;
    logic       ra_in_2, rb_in_2, rz_in_2, ra_out_2, rb_out_2, rz_out_2;
    logic       busy_2, done_2;
    logic [1:0] op_count_2;

    always #5 clock = ~clock;

    control_sequencer #(.CNT_W(8)) dut (
        .clock(clock), .clear(clear), .start(start), .op(op),
        .RAin(ra_in), .RBin(rb_in), .RZin(rz_in),
        .RAout(ra_out), .RBout(rb_out), .RZout(rz_out),
        .busy(busy), .done(done), .op_count(op_count)
    );

    control_sequencer #(.CNT_W(2)) dut_w2 (
        .clock(clock), .clear(clear), .start(start), .op(op),
        .RAin(ra_in_2), .RBin(rb_in_2), .RZin(rz_in_2),
        .RAout(ra_out_2), .RBout(rb_out_2), .RZout(rz_out_2),
        .busy(busy_2), .done(done_2), .op_count(op_count_2)
    );

    logic [7:0] w_ctrl, w_ctrl_2;
    assign w_ctrl   = {ra_in, rb_in, rz_in, ra_out, rb_out, rz_out, busy, done};
    assign w_ctrl_2 = {ra_in_2, rb_in_2, rz_in_2, ra_out_2, rb_out_2, rz_out_2, busy_2, done_2};

    // ---------------- attached datapath ----------------
    logic [7:0] dp_ra, dp_rb, dp_rz;
    logic [7:0] dp_a = 8'd0, dp_imm = 8'd0;
    logic [7:0] pre_ra = 8'd0, pre_rb = 8'd0, pre_rz = 8'd0;
    logic       dp_load = 1'b0;
    logic [7:0] w_bus, w_sum;

    assign w_bus = ra_out ? dp_ra : rb_out ? dp_rb : rz_out ? dp_rz : dp_imm;
    assign w_sum = dp_a + w_bus;

    always_ff @(posedge clock) begin
        if (dp_load) begin
            dp_ra <= pre_ra;
            dp_rb <= pre_rb;
            dp_rz <= pre_rz;
        end else begin
            if (ra_in) dp_ra <= w_bus;
            if (rb_in) dp_rb <= w_bus;
            if (rz_in) dp_rz <= w_sum;
        end
    end

    // ---------------- checking infrastructure ----------------
    int n_total = 0;
    int n_pass  = 0;
    int overlap = 0;
    int inst_diff = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    typedef struct {
        logic [7:0] ra, rb, rz;
        int         cnt;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   sb_ops = 0;

    // Per-cycle monitor: bus exclusivity, instance agreement, and the
    // scoreboard pop on every done pulse.
    always @(negedge clock) begin
        if ((int'(ra_out) + int'(rb_out) + int'(rz_out)) > 1) overlap++;
        if (w_ctrl != w_ctrl_2) inst_diff++;
        if (done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                check("sb_ra", int'(dp_ra), int'(mon_e.ra));
                check("sb_rb", int'(dp_rb), int'(mon_e.rb));
                check("sb_rz", int'(dp_rz), int'(mon_e.rz));
                check("sb_done_strobes", int'(w_ctrl[7:2]), 0);
                check("sb_count", int'(op_count), mon_e.cnt % 256);
                check("sb_count_w2", int'(op_count_2), mon_e.cnt % 4);
            end
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0] op;
        logic [7:0] a, imm, ra0, rb0, rz0;
        logic [7:0] ra, rb, rz;
        int         lat, busy_n, rain_n;
    } vec_t;

    vec_t vecs[7];
    vec_t lda_vec;

    task automatic preload(input logic [7:0] ra0, rb0, rz0, a, imm);
        @(posedge clock);
        #1;
        dp_load = 1'b1;
        pre_ra = ra0; pre_rb = rb0; pre_rz = rz0;
        dp_a = a; dp_imm = imm;
        @(posedge clock);
        #1;
        dp_load = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag, input bit from_clear);
        exp_t e;
        int   lat, bn, rn;
        bit   fin;
        preload(v.ra0, v.rb0, v.rz0, v.a, v.imm);
        e.ra = v.ra; e.rb = v.rb; e.rz = v.rz; e.cnt = sb_ops;
        sb_q.push_back(e);
        sb_ops++;
        if (from_clear) clear = 1'b0;
        start = 1'b1;
        op    = v.op;
        @(posedge clock);              // accepting edge
        #1;
        start = 1'b0;
        op    = ~v.op;                 // must not disturb the running op
        lat = -1; bn = 0; rn = 0; fin = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            if (done && lat < 0) lat = i - 1;
            if (ra_in) rn++;
            if (busy) bn++;
            else begin
                fin = 1'b1;
                break;
            end
        end
        check({tag, "_finished"}, int'(fin), 1);
        check({tag, "_latency"}, lat, v.lat);
        check({tag, "_busy_cycles"}, bn, v.busy_n);
        check({tag, "_rain_cycles"}, rn, v.rain_n);
        check({tag, "_count_after"}, int'(op_count), sb_ops % 256);
        check({tag, "_count_w2_after"}, int'(op_count_2), sb_ops % 4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wrap_exp[5];
        wrap_exp = '{1, 2, 3, 0, 1};

        //            op          a      imm    ra0    rb0    rz0    ra     rb     rz   lat busy rain
        vecs[0] = '{c_op_lda,   8'd0,  8'd7,  8'd1,  8'd2,  8'd3,  8'd7,  8'd2,  8'd3,  1, 2, 1};
        vecs[1] = '{c_op_movab, 8'd0,  8'd9,  8'd4,  8'd0,  8'd3,  8'd4,  8'd4,  8'd3,  1, 2, 0};
        vecs[2] = '{c_op_add,   8'd5,  8'd0,  8'd1,  8'd3,  8'd0,  8'd1,  8'd8,  8'd8,  2, 3, 0};
        vecs[3] = '{c_op_chain, 8'd5,  8'd7,  8'd0,  8'd0,  8'd0,  8'd7,  8'd12, 8'd12, 4, 5, 1};
        vecs[4] = '{c_op_add,   8'd200,8'd0,  8'd9,  8'd100,8'd0,  8'd9,  8'd44, 8'd44, 2, 3, 0};
        vecs[5] = '{c_op_chain, 8'd255,8'd1,  8'd0,  8'd0,  8'd0,  8'd1,  8'd0,  8'd0,  4, 5, 1};
        vecs[6] = '{c_op_lda,   8'd0,  8'hAA, 8'h55, 8'd0,  8'd0,  8'hAA, 8'd0,  8'd0,  1, 2, 1};
        lda_vec = '{c_op_lda,   8'd0,  8'd3,  8'd0,  8'd0,  8'd0,  8'd3,  8'd0,  8'd0,  1, 2, 1};

        // Reset state.
        @(posedge clock);
        @(posedge clock);
        #1;
        check("reset_ctrl", int'(w_ctrl), 0);
        check("reset_count", int'(op_count), 0);
        check("reset_count_w2", int'(op_count_2), 0);
        clear = 1'b0;

        // Table-driven operations.
        for (int k = 0; k < 7; k++) begin
            run_vec(vecs[k], $sformatf("vec%0d", k), 1'b0);
        end

        // start held high for 20 edges with MOVAB: one acceptance every
        // three cycles gives acceptances at edges 1,4,...,19 -> 7 ops.
        preload(8'h33, 8'h00, 8'h44, 8'd0, 8'd0);
        for (int k = 0; k < 7; k++) begin
            exp_t e;
            e.ra = 8'h33; e.rb = 8'h33; e.rz = 8'h44; e.cnt = sb_ops;
            sb_q.push_back(e);
            sb_ops++;
        end
        start = 1'b1;
        op    = c_op_movab;
        repeat (20) @(posedge clock);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        check("hold_queue_drained", sb_q.size(), 0);
        check("hold_count", int'(op_count), sb_ops % 256);

        // Abort a CHAIN in S_ADD.
        @(posedge clock);
        #1;
        clear = 1'b1;
        sb_ops = 0;
        #1;
        check("clear_ctrl", int'(w_ctrl), 0);
        check("clear_count", int'(op_count), 0);
        @(posedge clock);
        #1;
        clear = 1'b0;
        preload(8'd0, 8'd0, 8'd99, 8'd5, 8'd7);
        start = 1'b1;
        op    = c_op_chain;
        @(posedge clock);              // accept -> S_LDA
        #1;
        start = 1'b0;
        @(posedge clock);              // S_MOV
        @(posedge clock);              // S_ADD
        @(negedge clock);
        check("abort_in_add", int'(rz_in), 1);
        clear = 1'b1;
        #1;
        check("abort_ctrl", int'(w_ctrl), 0);
        check("abort_ctrl_w2", int'(w_ctrl_2), 0);
        check("abort_count", int'(op_count), 0);
        @(posedge clock);
        @(posedge clock);
        #1;
        check("abort_rz_kept", int'(dp_rz), 99);
        check("abort_rb_moved", int'(dp_rb), 7);

        // Five LDA ops; the first is accepted on the first edge after clear
        // releases. The 2-bit counter must read 1,2,3,0,1.
        for (int k = 0; k < 5; k++) begin
            run_vec(lda_vec, $sformatf("wrap%0d", k), k == 0);
            check($sformatf("wrap_seq%0d", k), int'(op_count_2), wrap_exp[k]);
        end

        repeat (3) @(posedge clock);
        #1;
        check("bus_overlap_cycles", overlap, 0);
        check("instance_diff_cycles", inst_diff, 0);
        check("final_queue_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_control_sequencer
`default_nettype wire

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001: Parameter CNT_W, default 8, width of the completed-operation counter.
REQ-002: clock  input  1  single rising-edge clock for all state.
REQ-003: clear  input  1  asynchronous, active-high reset.
REQ-004: start  input  1  request to begin one operation; sampled only in IDLE.
REQ-005: op  input  2  operation code: 00 LDA, 01 MOVAB, 10 ADD, 11 CHAIN; captured when start is accepted.
REQ-006: RAin, RBin, RZin  output  1 each  register load strobes to the datapath.
REQ-007: RAout, RBout, RZout  output  1 each  bus driver selects to the datapath.
REQ-008: busy  output  1  high in every state except IDLE.
REQ-009: done  output  1  one-cycle pulse marking completion of an operation.
REQ-010: op_count  output  CNT_W  number of completed operations; wraps modulo 2^CNT_W.

Function
REQ-011: The FSM SHALL have states IDLE, S_LDA, S_MOV, S_ADD, S_WB and DONE.
REQ-012: All strobe, select, busy and done outputs SHALL be Moore outputs, registered and decoded from the state only.
REQ-013: Strobes and selects per state:
- S_LDA: RAin only.
- S_MOV: RAout and RBin.
- S_ADD: RBout and RZin.
- S_WB: RZout and RBin.
- IDLE and DONE: all low.
REQ-014: At most one of RAout, RBout and RZout SHALL be high in any cycle.
REQ-015: In IDLE with start high at edge k, the sequencer SHALL latch op and enter the first execute state at edge k.
REQ-016: Execute-state sequences:
- LDA: S_LDA.
- MOVAB: S_MOV.
- ADD: S_ADD, then S_WB.
- CHAIN: S_LDA, S_MOV, S_ADD, then S_WB.
- Each execute state SHALL last exactly one cycle.
REQ-017: The cycle counts from the accepting edge to done high SHALL be: LDA 1, MOVAB 1, ADD 2, CHAIN 4.
REQ-018: After the last execute state the FSM SHALL enter DONE for one cycle, assert done, increment op_count at the DONE-exit edge, and then return to IDLE.
REQ-019: start while busy SHALL be ignored, with no queuing; start held high through DONE SHALL be accepted only once the FSM is back in IDLE.
REQ-020: A change on op after acceptance SHALL have no effect on the operation in progress.
REQ-021: op_count SHALL wrap from 2^CNT_W-1 to 0 without a flag.

Reset
REQ-022: When clear is asserted, the following SHALL take effect immediately and asynchronously:
- state becomes IDLE;
- all strobes and selects go low;
- busy = 0, done = 0, op_count = 0, latched op = 00.
REQ-023: clear asserted during an operation SHALL abort it without a done pulse and without incrementing op_count.
REQ-024: On the first edge after clear deasserts, the FSM SHALL be in IDLE and SHALL accept start.

Structure
REQ-025: The state encodings and op codes (LDA, MOVAB, ADD, CHAIN) SHALL be defined as localparams in a shared package or include file used by control_sequencer and its bench.
REQ-026: control_sequencer SHALL be a single module with no sub-modules.
REQ-027: control_sequencer SHALL connect directly to the datapath control inputs, with no glue logic.

Verification
REQ-028: After clear, pulse start with op=00 -> RAin high for exactly 1 cycle, done 1 cycle later, op_count=1.
REQ-029: With the datapath attached, A=5, immediate=7, op=11 -> after done: RA=7, RB=12, RZ=12; busy high for 5 cycles; bus selects never overlap.
REQ-030: op=10 with RB=3 and A=5 -> RZ=8, then RB=8; done 2 cycles after acceptance.
REQ-031: Hold start high for 20 cycles with op=01 -> one acceptance per 3-cycle period (MOV, DONE, IDLE); op_count increments by 1 per done.
REQ-032: Assert clear during S_ADD of a CHAIN operation -> all outputs low immediately, no done pulse, op_count unchanged at 0, RZ not loaded.
REQ-033: With CNT_W=2, run 5 LDA operations -> op_count sequence 1, 2, 3, 0, 1.
